wb_trace_fifo: RTL and testbench
================================

Name: wb_trace_fifo

Overview:
- Capture buffer downstream of Simple_Single_CPU.
- Snoops register-file and data-memory write strobes every cycle and turns them into timestamped trace entries.
- Buffers entries in a FIFO and drains them over a valid/ready port to the bench checker or a debug sink.
- Replaces per-cycle full-state dumps with an exact, ordered write log.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 4.
- CYC_W, 16, width of the cycle timestamp counter.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- enable_i  input  1  capture enable, driven by the CPU start/run signal.
- pc_i  input  32  PC of the instruction retiring this cycle.
- rf_we_i  input  1  register-file write strobe.
- rf_waddr_i  input  5  register write address.
- rf_wdata_i  input  32  register write data.
- mem_we_i  input  1  data-memory write strobe.
- mem_addr_i  input  32  data-memory byte address.
- mem_wdata_i  input  32  data-memory write data.
- trc_ready_i  input  1  sink accepts the head entry.
- trc_valid_o  output  1  head entry present.
- trc_kind_o  output  2  2'b01 register write, 2'b10 memory write.
- trc_pc_o  output  32  head PC.
- trc_addr_o  output  32  head address; zero-extended rf_waddr for register writes.
- trc_data_o  output  32  head write data.
- trc_cycle_o  output  CYC_W  head timestamp.
- count_o  output  log2(DEPTH)+1  current occupancy.
- full_o  output  1  count_o == DEPTH.
- empty_o  output  1  count_o == 0.
- overflow_cnt_o  output  8  number of dropped capture cycles; saturates at 255.

Behaviour:
- Reset (asynchronous, rst_i=1):
  - Pointers, count, cycle counter and overflow_cnt_o clear to 0.
  - trc_valid_o=0, empty_o=1, full_o=0.
  - trc_kind_o, trc_pc_o, trc_addr_o, trc_data_o and trc_cycle_o read 0.
  - Reset asserted mid-operation discards all buffered entries immediately.
- Cycle counter:
  - Increments by 1 on each clock with enable_i=1.
  - Holds when enable_i=0; wraps modulo 2^CYC_W.
  - An entry's timestamp is the counter value before the increment in its capture cycle.
- Event qualification (only when enable_i=1):
  - reg event = rf_we_i && rf_waddr_i != 0. Writes to R0 are never logged.
  - mem event = mem_we_i.
- Capture and ordering:
  - Need = number of qualified events this cycle (0, 1 or 2).
  - When both events occur in one cycle, the register entry is written first and the memory entry second, in consecutive slots.
- Free-slot rule:
  - free = DEPTH - count + (pop this cycle ? 1 : 0).
  - If need <= free, all events are pushed.
  - If need > free, the whole cycle is dropped (never partial) and overflow_cnt_o increments by 1 (saturating). Buffered entries are unaffected.
- Drain:
  - First-word-fall-through: head fields are valid combinationally whenever trc_valid_o=1, and trc_valid_o = !empty_o.
  - Pop occurs when trc_valid_o && trc_ready_i.
  - When empty, head fields read 0.
  - Head fields stay stable while trc_valid_o=1 and trc_ready_i=0.
- Simultaneous push and pop are allowed in the same cycle:
  - count_next = count + pushes - pop.
  - At full, a single-event push concurrent with a pop is accepted.
  - At empty, a pushed entry appears at the head on the next cycle (latency 1); no same-cycle bypass.
- Pointers: wrap modulo DEPTH. Occupancy is tracked by count, so full and empty are unambiguous.
- enable_i=0: no captures, but draining continues normally.

Test Plan:
- Reset then single event: rst_i pulse, enable_i=1, rf_we_i=1, rf_waddr_i=8, rf_wdata_i=0x0000002A, pc_i=0x10 for one cycle, trc_ready_i=1 -> next cycle trc_valid_o=1 for one cycle with kind 01, addr 8, data 42, pc 0x10, cycle 0; count_o then returns to 0.
- R0 filter plus dual event:
  - Write to R0 -> no entry.
  - Next cycle rf write R3=5 together with mem write [0x20]=7 -> two entries in order {01,3,5} then {10,0x20,7}, both carrying the same timestamp.
- Fill and overflow:
  - trc_ready_i=0, 16 single events -> full_o=1, count_o=16.
  - 17th event -> dropped, overflow_cnt_o=1.
  - Dual event at count 15 -> both dropped, overflow_cnt_o increments, count_o stays 15.
- Push/pop at full: full FIFO, trc_ready_i=1 with a concurrent single event -> count_o stays 16, head advances, new entry lands at the tail; the final drain yields all entries in order.
- Enable gating and wrap:
  - enable_i=0 for 5 cycles with strobes active -> no entries, timestamp unchanged.
  - Run 40 mixed events through DEPTH=16 with random ready -> output sequence matches the scoreboard exactly, proving pointer wrap.
- Reset mid-drain: 6 entries buffered, assert rst_i between clock edges -> trc_valid_o drops to 0 immediately, and count_o, overflow_cnt_o and the timestamp all read 0 after release.

Source files
------------

// File: rtl/wb_trace_fifo.sv
// Trace capture FIFO: snoops register-file and data-memory write strobes and
// logs them as timestamped entries, drained over a first-word-fall-through valid/ready port.
module wb_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int CYC_W = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic [31:0]               pc_i,
  input  logic                      rf_we_i,
  input  logic [4:0]                rf_waddr_i,
  input  logic [31:0]               rf_wdata_i,
  input  logic                      mem_we_i,
  input  logic [31:0]               mem_addr_i,
  input  logic [31:0]               mem_wdata_i,
  input  logic                      trc_ready_i,
  output logic                      trc_valid_o,
  output logic [1:0]                trc_kind_o,
  output logic [31:0]               trc_pc_o,
  output logic [31:0]               trc_addr_o,
  output logic [31:0]               trc_data_o,
  output logic [CYC_W-1:0]          trc_cycle_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [7:0]                overflow_cnt_o
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  typedef struct packed {
    logic [1:0]       kind;
    logic [31:0]      pc;
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [CYC_W-1:0] cyc;
  } entry_t;

  entry_t           mem [DEPTH];
  ptr_t             wr_ptr, rd_ptr, wr_ptr2;
  cnt_t             count, need, free, pushes;
  logic [CYC_W-1:0] cyc;
  logic [7:0]       ovf;
  logic             reg_ev, mem_ev, pop, push_ok;
  entry_t           reg_ent, mem_ent, head;

  always_comb begin
    reg_ev  = enable_i && rf_we_i && (rf_waddr_i != '0);
    mem_ev  = enable_i && mem_we_i;
    need    = cnt_t'(reg_ev) + cnt_t'(mem_ev);
    pop     = (count != '0) && trc_ready_i;
    // A slot freed by this cycle's pop is reusable by this cycle's push.
    free    = cnt_t'(DEPTH) - count + cnt_t'(pop);
    push_ok = (need <= free);
    pushes  = push_ok ? need : '0;
    wr_ptr2 = wr_ptr + ptr_t'(reg_ev);
    reg_ent = '{kind: 2'b01, pc: pc_i, addr: {27'b0, rf_waddr_i}, data: rf_wdata_i, cyc: cyc};
    mem_ent = '{kind: 2'b10, pc: pc_i, addr: mem_addr_i, data: mem_wdata_i, cyc: cyc};
  end

  // Entry storage carries no reset; the head is masked to zero while empty.
  always_ff @(posedge clk_i) begin
    if (push_ok && reg_ev) mem[wr_ptr]  <= reg_ent;
    if (push_ok && mem_ev) mem[wr_ptr2] <= mem_ent;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      cyc    <= '0;
      ovf    <= '0;
    end else begin
      wr_ptr <= wr_ptr + ptr_t'(pushes);
      rd_ptr <= rd_ptr + ptr_t'(pop);
      count  <= count + pushes - cnt_t'(pop);
      if (enable_i) cyc <= cyc + 1'b1;
      if (!push_ok && ovf != '1) ovf <= ovf + 1'b1;
    end
  end

  always_comb begin
    head           = mem[rd_ptr];
    empty_o        = (count == '0);
    full_o         = (count == cnt_t'(DEPTH));
    trc_valid_o    = !empty_o;
    trc_kind_o     = trc_valid_o ? head.kind : '0;
    trc_pc_o       = trc_valid_o ? head.pc   : '0;
    trc_addr_o     = trc_valid_o ? head.addr : '0;
    trc_data_o     = trc_valid_o ? head.data : '0;
    trc_cycle_o    = trc_valid_o ? head.cyc  : '0;
    count_o        = count;
    overflow_cnt_o = ovf;
  end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed bench for wb_trace_fifo: hand-computed checks plus an ordered
// expected-entry queue compared at every pop.
module tb_wb_trace_fifo;
  localparam int DEPTH = 16;
  localparam int CYC_W = 16;

  logic             clk = 1'b0;
  logic             rst_i, enable_i, rf_we_i, mem_we_i, trc_ready_i;
  logic [31:0]      pc_i, rf_wdata_i, mem_addr_i, mem_wdata_i;
  logic [4:0]       rf_waddr_i;
  logic             trc_valid_o, full_o, empty_o;
  logic [1:0]       trc_kind_o;
  logic [31:0]      trc_pc_o, trc_addr_o, trc_data_o;
  logic [CYC_W-1:0] trc_cycle_o;
  logic [4:0]       count_o;
  logic [7:0]       overflow_cnt_o;

  always #5 clk = ~clk;

  wb_trace_fifo #(.DEPTH(DEPTH), .CYC_W(CYC_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .pc_i(pc_i),
    .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i), .rf_wdata_i(rf_wdata_i),
    .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .trc_ready_i(trc_ready_i), .trc_valid_o(trc_valid_o), .trc_kind_o(trc_kind_o),
    .trc_pc_o(trc_pc_o), .trc_addr_o(trc_addr_o), .trc_data_o(trc_data_o),
    .trc_cycle_o(trc_cycle_o), .count_o(count_o), .full_o(full_o),
    .empty_o(empty_o), .overflow_cnt_o(overflow_cnt_o)
  );

  typedef struct packed {
    logic [1:0]       kind;
    logic [31:0]      pc;
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [CYC_W-1:0] cyc;
  } ent_t;

  ent_t             q[$];
  int unsigned      n_cmp = 0;
  int unsigned      n_bad = 0;
  logic [CYC_W-1:0] exp_cyc = '0;
  int unsigned      exp_ovf = 0;
  logic [CYC_W-1:0] ts_saved;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ev(input logic r, input logic [4:0] ra, input logic [31:0] rd,
                        input logic m, input logic [31:0] ma, input logic [31:0] md,
                        input logic [31:0] pc);
    rf_we_i = r; rf_waddr_i = ra; rf_wdata_i = rd;
    mem_we_i = m; mem_addr_i = ma; mem_wdata_i = md; pc_i = pc;
  endtask

  task automatic idle();
    set_ev(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
  endtask

  // One clock: checks the head on a pop, then updates the expected queue.
  task automatic tick();
    logic pop, re, me, en;
    int   need, free;
    ent_t er, em;
    en   = enable_i;
    pop  = (q.size() != 0) && trc_ready_i;
    re   = enable_i && rf_we_i && (rf_waddr_i != 5'd0);
    me   = enable_i && mem_we_i;
    need = int'(re) + int'(me);
    free = DEPTH - q.size() + int'(pop);
    er   = '{kind: 2'b01, pc: pc_i, addr: {27'b0, rf_waddr_i}, data: rf_wdata_i, cyc: exp_cyc};
    em   = '{kind: 2'b10, pc: pc_i, addr: mem_addr_i, data: mem_wdata_i, cyc: exp_cyc};
    if (pop) begin
      chk("head_kind",  64'(trc_kind_o),  64'(q[0].kind));
      chk("head_pc",    64'(trc_pc_o),    64'(q[0].pc));
      chk("head_addr",  64'(trc_addr_o),  64'(q[0].addr));
      chk("head_data",  64'(trc_data_o),  64'(q[0].data));
      chk("head_cycle", 64'(trc_cycle_o), 64'(q[0].cyc));
    end
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (need <= free) begin
      if (re) q.push_back(er);
      if (me) q.push_back(em);
    end else if (exp_ovf < 255) begin
      exp_ovf++;
    end
    if (en) exp_cyc = exp_cyc + 1'b1;
    chk("count", 64'(count_o), 64'(q.size()));
    chk("ovf",   64'(overflow_cnt_o), 64'(exp_ovf));
    chk("valid", 64'(trc_valid_o), 64'(q.size() != 0));
  endtask

  initial begin
    rst_i = 1'b1; enable_i = 1'b0; trc_ready_i = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(trc_valid_o), 64'd0);
    chk("rst_empty", 64'(empty_o), 64'd1);
    chk("rst_full",  64'(full_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_ovf",   64'(overflow_cnt_o), 64'd0);
    chk("rst_head",  64'(trc_kind_o) | 64'(trc_pc_o) | 64'(trc_addr_o) | 64'(trc_data_o) | 64'(trc_cycle_o), 64'd0);
    rst_i = 1'b0;

    // Single register write, drained immediately.
    enable_i = 1'b1; trc_ready_i = 1'b1;
    set_ev(1'b1, 5'd8, 32'h2A, 1'b0, 32'd0, 32'd0, 32'h10);
    tick();
    idle();
    chk("t1_valid", 64'(trc_valid_o), 64'd1);
    chk("t1_kind",  64'(trc_kind_o), 64'h1);
    chk("t1_addr",  64'(trc_addr_o), 64'd8);
    chk("t1_data",  64'(trc_data_o), 64'd42);
    chk("t1_pc",    64'(trc_pc_o), 64'h10);
    chk("t1_cycle", 64'(trc_cycle_o), 64'd0);
    tick();
    chk("t1_drained", 64'(count_o), 64'd0);

    // R0 write is filtered; dual event lands reg-first with one timestamp.
    set_ev(1'b1, 5'd0, 32'd99, 1'b0, 32'd0, 32'd0, 32'h20);
    tick();
    chk("r0_count", 64'(count_o), 64'd0);
    trc_ready_i = 1'b0;
    set_ev(1'b1, 5'd3, 32'd5, 1'b1, 32'h20, 32'd7, 32'h24);
    tick();
    idle();
    chk("dual_count", 64'(count_o), 64'd2);
    chk("dual0_kind", 64'(trc_kind_o), 64'h1);
    chk("dual0_addr", 64'(trc_addr_o), 64'd3);
    chk("dual0_data", 64'(trc_data_o), 64'd5);
    chk("dual0_cyc",  64'(trc_cycle_o), 64'd3);
    trc_ready_i = 1'b1;
    tick();
    chk("dual1_kind", 64'(trc_kind_o), 64'h2);
    chk("dual1_addr", 64'(trc_addr_o), 64'h20);
    chk("dual1_data", 64'(trc_data_o), 64'd7);
    chk("dual1_cyc",  64'(trc_cycle_o), 64'd3);
    tick();
    chk("dual_empty", 64'(empty_o), 64'd1);

    // Fill to DEPTH, then overflow with a single and a dual event.
    trc_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_ev(1'b1, 5'((i % 31) + 1), 32'h100 + i, 1'b0, 32'd0, 32'd0, 32'h1000 + 4 * i);
      tick();
    end
    chk("fill_full",  64'(full_o), 64'd1);
    chk("fill_count", 64'(count_o), 64'd16);
    set_ev(1'b1, 5'd17, 32'h1FF, 1'b0, 32'd0, 32'd0, 32'h1100);
    tick();
    chk("ovf1_count", 64'(count_o), 64'd16);
    chk("ovf1_cnt",   64'(overflow_cnt_o), 64'd1);
    idle();
    trc_ready_i = 1'b1;
    tick();
    chk("pop_to_15", 64'(count_o), 64'd15);
    trc_ready_i = 1'b0;
    set_ev(1'b1, 5'd9, 32'h300, 1'b1, 32'h300, 32'h301, 32'h1200);
    tick();
    chk("ovf2_count", 64'(count_o), 64'd15);
    chk("ovf2_cnt",   64'(overflow_cnt_o), 64'd2);

    // Concurrent push and pop while full.
    set_ev(1'b1, 5'd10, 32'h400, 1'b0, 32'd0, 32'd0, 32'h1300);
    tick();
    chk("refill_full", 64'(full_o), 64'd1);
    trc_ready_i = 1'b1;
    set_ev(1'b0, 5'd0, 32'd0, 1'b1, 32'h500, 32'h501, 32'h1400);
    tick();
    chk("pp_count", 64'(count_o), 64'd16);
    chk("pp_full",  64'(full_o), 64'd1);
    idle();
    for (int i = 0; i < 40 && q.size() != 0; i++) tick();
    chk("pp_drained", 64'(empty_o), 64'd1);

    // Enable gating: strobes ignored and timestamp frozen while disabled.
    ts_saved = exp_cyc;
    enable_i = 1'b0;
    set_ev(1'b1, 5'd4, 32'h600, 1'b1, 32'h600, 32'h601, 32'h1500);
    repeat (5) tick();
    chk("gate_count", 64'(count_o), 64'd0);
    enable_i = 1'b1; trc_ready_i = 1'b0;
    set_ev(1'b1, 5'd5, 32'h700, 1'b0, 32'd0, 32'd0, 32'h1600);
    tick();
    idle();
    chk("gate_ts", 64'(trc_cycle_o), 64'(ts_saved));
    trc_ready_i = 1'b1;
    tick();

    // Mixed traffic with random ready; wraps the pointers several times.
    for (int i = 0; i < 40; i++) begin
      set_ev((i % 3) != 1, 5'((i % 31) + 1), 32'hA000 + i,
             (i % 3) != 0, 32'h4000 + 4 * i, 32'hB000 + i, 32'h2000 + 4 * i);
      trc_ready_i = 1'($urandom_range(0, 1));
      tick();
    end
    idle();
    trc_ready_i = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) tick();
    chk("wrap_drained", 64'(empty_o), 64'd1);

    // Asynchronous reset with entries buffered.
    trc_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_ev(1'b1, 5'(i + 1), 32'hC00 + i, 1'b0, 32'd0, 32'd0, 32'h3000 + 4 * i);
      tick();
    end
    chk("pre_rst_count", 64'(count_o), 64'd6);
    idle();
    enable_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    chk("arst_valid", 64'(trc_valid_o), 64'd0);
    chk("arst_count", 64'(count_o), 64'd0);
    chk("arst_empty", 64'(empty_o), 64'd1);
    chk("arst_data",  64'(trc_data_o), 64'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    q.delete();
    exp_cyc = '0;
    exp_ovf = 0;
    chk("post_rst_count", 64'(count_o), 64'd0);
    chk("post_rst_ovf",   64'(overflow_cnt_o), 64'd0);
    enable_i = 1'b1;
    set_ev(1'b1, 5'd7, 32'hD00, 1'b0, 32'd0, 32'd0, 32'h4000);
    tick();
    idle();
    chk("post_rst_ts",    64'(trc_cycle_o), 64'd0);
    chk("post_rst_valid", 64'(trc_valid_o), 64'd1);
    trc_ready_i = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
